// File: rtl/switch_io_ctrl_pkg.sv
// Shared widths and FSM state type for the switch/LED operand handshake.
// Latency: n/a (types and constants only); backpressure: n/a.
package switch_io_ctrl_pkg;

    localparam int LED_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_XLO    = 3'd1,
        WAIT_Y      = 3'd2,
        REQ         = 3'd3,
        WAIT_RES    = 3'd4,
        SHOW_X_WAIT = 3'd5,
        SHOW_X      = 3'd6,
        SHOW_Y      = 3'd7
    } ctrl_state_t;

    function automatic logic state_busy(input ctrl_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/switch_io_ctrl_if.sv
// Board pins plus core operand/result handshake bundled as one port.
// Latency: wires only; backpressure: op_valid/op_ready on the operand path.
interface switch_io_ctrl_if
    import switch_io_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = LED_WIDTH
);
    logic [DATA_WIDTH-1:0] sw_data;
    logic                  sw_strobe;
    logic [DATA_WIDTH-1:0] led;
    logic [DATA_WIDTH-1:0] op_x;
    logic [DATA_WIDTH-1:0] op_y;
    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] res_x;
    logic [DATA_WIDTH-1:0] res_y;
    logic                  res_valid;
    logic                  busy;

    modport master (
        input  sw_data, sw_strobe, op_ready, res_x, res_y, res_valid,
        output led, op_x, op_y, op_valid, busy
    );

    modport slave (
        output sw_data, sw_strobe, op_ready, res_x, res_y, res_valid,
        input  led, op_x, op_y, op_valid, busy
    );
endinterface

// File: rtl/switch_debounce.sv
// Synchronises a raw switch and toggles db after DEBOUNCE_CYCLES stable cycles.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES from pin edge to db; no backpressure.
module switch_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic nReset,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised level matches db restarts the count.
    always_comb begin
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_lvl != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = sync_lvl;
                rise_d = sync_lvl;
                fall_d = ~sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/switch_io_ctrl.sv
// Captures x/y from debounced strobe presses, hands them to the core, shows results on LEDs.
// Latency: one cycle after each debounced edge; op_valid held until op_ready.
module switch_io_ctrl
    import switch_io_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = LED_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             nReset,
    switch_io_ctrl_if.master bus
);
    ctrl_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] op_x_q, op_x_d;
    logic [DATA_WIDTH-1:0] op_y_q, op_y_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] ry_q, ry_d;
    logic [DATA_WIDTH-1:0] led_q, led_d;
    logic                  db, rise, fall;

    switch_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_strobe (
        .clk    (clk),
        .nReset (nReset),
        .raw_i  (bus.sw_strobe),
        .db_o   (db),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
        end else begin
            data_sync_q[0] <= bus.sw_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        led_d   = led_q;
        case (state_q)
            IDLE: if (rise) begin
                op_x_d  = data_sync_q[SYNC_STAGES-1];
                state_d = WAIT_XLO;
            end
            WAIT_XLO: if (fall) state_d = WAIT_Y;
            WAIT_Y: if (rise) begin
                op_y_d  = data_sync_q[SYNC_STAGES-1];
                state_d = REQ;
            end
            REQ: if (bus.op_ready) state_d = WAIT_RES;
            WAIT_RES: if (bus.res_valid) begin
                rx_d    = bus.res_x;
                ry_d    = bus.res_y;
                state_d = SHOW_X_WAIT;
            end
            // Level check: a release during REQ/WAIT_RES has already dropped db.
            SHOW_X_WAIT: if (!db) begin
                led_d   = rx_q;
                state_d = SHOW_X;
            end
            SHOW_X: if (rise) begin
                led_d   = ry_q;
                state_d = SHOW_Y;
            end
            SHOW_Y: if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            op_x_q  <= '0;
            op_y_q  <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            led_q   <= led_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.op_x     = op_x_q;
    assign bus.op_y     = op_y_q;
    assign bus.op_valid = (state_q == REQ);
    assign bus.busy     = state_busy(state_q);
endmodule

// File: tb/tb_switch_io_ctrl.sv
// Bench for switch_io_ctrl: scripted presses with random operands, stub core, transaction-level model.
module tb_switch_io_ctrl;
    import switch_io_ctrl_pkg::*;

    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int DC  = 16;
    localparam int LAT = SS + DC;

    logic clk = 1'b0;
    logic nReset;
    int   checks   = 0;
    int   failures = 0;
    int   xfers    = 0;
    logic [7:0] model_led;

    always #5 clk = ~clk;

    switch_io_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    switch_io_ctrl #(
        .DATA_WIDTH      (DW),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    always @(posedge clk) if (nReset && bus.op_valid && bus.op_ready) xfers <= xfers + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full two-press transaction; expectations come from x+1 / y-1 and the press timing.
    task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input int rdy_delay,
                           input int res_delay, input bit early, input string tag);
        logic [7:0] ex_rx, ey;
        int xfers0;
        ex_rx  = x + 8'd1;
        ey     = y - 8'd1;
        xfers0 = xfers;
        bus.sw_data = x;
        step(3);
        bus.sw_strobe = 1'b1;
        step(LAT + 4);
        checks++;
        if (bus.op_x !== x || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_x_capture op_x=%h busy=%b expected op_x=%h busy=1", tag, bus.op_x, bus.busy, x);
        end
        bus.sw_strobe = 1'b0;
        step(2);
        bus.sw_data = ~x;
        step(LAT + 2);
        bus.sw_data = y;
        step(3);
        bus.sw_strobe = 1'b1;
        step(LAT);
        checks++;
        if (bus.op_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_valid_early op_valid=%b expected 0", tag, bus.op_valid);
        end
        step(1);
        checks++;
        if (bus.op_valid !== 1'b1 || bus.op_x !== x || bus.op_y !== y) begin
            failures++;
            $display("FAIL %s_request valid=%b op_x=%h op_y=%h expected 1 %h %h", tag, bus.op_valid, bus.op_x, bus.op_y, x, y);
        end
        for (int i = 0; i < rdy_delay; i++) begin
            step(1);
            checks++;
            if (bus.op_valid !== 1'b1 || bus.op_x !== x || bus.op_y !== y) begin
                failures++;
                $display("FAIL %s_hold cycle=%0d valid=%b op_x=%h op_y=%h expected 1 %h %h", tag, i, bus.op_valid, bus.op_x, bus.op_y, x, y);
            end
        end
        bus.op_ready = 1'b1;
        step(1);
        bus.op_ready = 1'b0;
        checks++;
        if (bus.op_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_transfer op_valid=%b expected 0", tag, bus.op_valid);
        end
        if (early) bus.sw_strobe = 1'b0;
        step(res_delay);
        bus.res_x     = ex_rx;
        bus.res_y     = ey;
        bus.res_valid = 1'b1;
        step(1);
        bus.res_valid = 1'b0;
        bus.res_x     = 8'($urandom);
        bus.res_y     = 8'($urandom);
        checks++;
        if (bus.led !== model_led) begin
            failures++;
            $display("FAIL %s_led_hold led=%h expected %h", tag, bus.led, model_led);
        end
        if (!early) begin
            step(4);
            checks++;
            if (bus.led !== model_led) begin
                failures++;
                $display("FAIL %s_led_pressed led=%h expected %h", tag, bus.led, model_led);
            end
            bus.sw_strobe = 1'b0;
            step(LAT);
            checks++;
            if (bus.led !== model_led) begin
                failures++;
                $display("FAIL %s_led_pre_x led=%h expected %h", tag, bus.led, model_led);
            end
        end
        step(1);
        checks++;
        if (bus.led !== ex_rx) begin
            failures++;
            $display("FAIL %s_led_x led=%h expected %h", tag, bus.led, ex_rx);
        end
        model_led = ex_rx;
        step(4);
        bus.sw_strobe = 1'b1;
        step(LAT);
        checks++;
        if (bus.led !== model_led) begin
            failures++;
            $display("FAIL %s_led_pre_y led=%h expected %h", tag, bus.led, model_led);
        end
        step(1);
        checks++;
        if (bus.led !== ey) begin
            failures++;
            $display("FAIL %s_led_y led=%h expected %h", tag, bus.led, ey);
        end
        model_led = ey;
        bus.sw_strobe = 1'b0;
        step(LAT);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_pre_idle busy=%b expected 1", tag, bus.busy);
        end
        step(1);
        checks++;
        if (bus.busy !== 1'b0 || bus.led !== ey || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL %s_idle busy=%b led=%h state=%0d expected 0 %h %0d", tag, bus.busy, bus.led, dut.state_q, ey, IDLE);
        end
        checks++;
        if (xfers != xfers0 + 1) begin
            failures++;
            $display("FAIL %s_xfer_count got=%0d expected 1", tag, xfers - xfers0);
        end
    endtask

    task automatic test_reset();
        nReset        = 1'b0;
        bus.sw_data   = '0;
        bus.sw_strobe = 1'b0;
        bus.op_ready  = 1'b0;
        bus.res_x     = '0;
        bus.res_y     = '0;
        bus.res_valid = 1'b0;
        step(3);
        checks++;
        if (bus.led !== 8'h00 || bus.op_x !== 8'h00 || bus.op_y !== 8'h00) begin
            failures++;
            $display("FAIL reset_data led=%h op_x=%h op_y=%h expected 00", bus.led, bus.op_x, bus.op_y);
        end
        checks++;
        if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_ctrl valid=%b busy=%b state=%0d expected 0 0 0", bus.op_valid, bus.busy, dut.state_q);
        end
        nReset = 1'b1;
        step(2);
        model_led = 8'h00;
    endtask

    task automatic test_basic();
        run_txn(8'h04, 8'hF8, 0, 2, 1'b0, "basic");
    endtask

    task automatic test_reset_mid();
        bus.sw_data = 8'h05;
        step(3);
        bus.sw_strobe = 1'b1;
        step(LAT + 4);
        checks++;
        if (bus.op_x !== 8'h05 || dut.state_q !== WAIT_XLO) begin
            failures++;
            $display("FAIL mid_x_capture op_x=%h state=%0d expected 05 %0d", bus.op_x, dut.state_q, WAIT_XLO);
        end
        bus.sw_strobe = 1'b0;
        step(LAT + 4);
        checks++;
        if (dut.state_q !== WAIT_Y) begin
            failures++;
            $display("FAIL mid_wait_y state=%0d expected %0d", dut.state_q, WAIT_Y);
        end
        nReset = 1'b0;
        #2;
        checks++;
        if (bus.led !== 8'h00 || bus.op_x !== 8'h00 || bus.op_y !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_data led=%h op_x=%h op_y=%h expected 00", bus.led, bus.op_x, bus.op_y);
        end
        checks++;
        if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL mid_reset_ctrl valid=%b busy=%b state=%0d expected 0 0 0", bus.op_valid, bus.busy, dut.state_q);
        end
        step(2);
        nReset = 1'b1;
        step(2);
        model_led = 8'h00;
        run_txn(8'h5A, 8'hA5, 1, 3, 1'b0, "post_reset");
    endtask

    task automatic test_debounce();
        int n;
        bus.sw_data = 8'h3C;
        step(3);
        bus.sw_strobe = 1'b1;
        step(DC - 1);
        bus.sw_strobe = 1'b0;
        step(LAT + 5);
        checks++;
        if (bus.busy !== 1'b0 || dut.u_strobe.db_o !== 1'b0) begin
            failures++;
            $display("FAIL deb_short_pulse busy=%b db=%b expected 0 0", bus.busy, dut.u_strobe.db_o);
        end
        bus.sw_strobe = 1'b1;
        n = 0;
        while (dut.u_strobe.db_o !== 1'b1 && n < LAT + 10) begin
            step(1);
            n++;
            if (n == DC) bus.sw_strobe = 1'b0;
        end
        checks++;
        if (n != LAT) begin
            failures++;
            $display("FAIL deb_latency cycles=%0d expected %0d", n, LAT);
        end
        step(1);
        checks++;
        if (bus.busy !== 1'b1 || bus.op_x !== 8'h3C) begin
            failures++;
            $display("FAIL deb_capture busy=%b op_x=%h expected 1 3c", bus.busy, bus.op_x);
        end
        nReset = 1'b0;
        step(2);
        nReset = 1'b1;
        step(2);
        model_led = 8'h00;
    endtask

    task automatic test_backpressure();
        run_txn(8'($urandom), 8'($urandom), 20, 2, 1'b0, "backpressure");
    endtask

    task automatic test_early_release();
        run_txn(8'($urandom), 8'($urandom), 0, 50, 1'b1, "early");
    endtask

    task automatic test_sweep();
        logic [7:0] cx [4];
        logic [7:0] cy [4];
        cx = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        cy = '{8'h7F, 8'h80, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) run_txn(cx[i], cy[i], 0, 2, 1'b0, "sweep_corner");
        for (int i = 0; i < 8; i++)
            run_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 6)), 1'b0, "sweep_rand");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_debounce();
        test_backpressure();
        test_early_release();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/switch_io_ctrl.md
Name: switch_io_ctrl

Overview:
- Board-side responder for the two-operand switch/LED handshake that drives the affine-transform core.
- Debounces the strobe switch and captures x on the first strobe press and y on the second.
- Passes the (x, y) pair to the compute core over a valid/ready interface.
- Displays x_res while the strobe is released and y_res while it is pressed again, then returns to idle.
- Sits between the top-level SW/LED pins and the core. Replaces software polling of the strobe switch.

Parameters:
- DATA_WIDTH, 8, width of operands, results and LED bus; two's complement.
- SYNC_STAGES, 2, flip-flop stages in the synchroniser on sw_strobe and sw_data; minimum 2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before the debounced strobe level changes; minimum 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nReset  in  1  reset, asynchronous assert, active-low.
- sw_data  in  DATA_WIDTH  raw switch operand (SW[DATA_WIDTH-1:0]).
- sw_strobe  in  1  raw strobe switch (SW8).
- led  out  DATA_WIDTH  LED display value.
- op_x  out  DATA_WIDTH  captured x operand.
- op_y  out  DATA_WIDTH  captured y operand.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  core accepts operands.
- res_x  in  DATA_WIDTH  transformed x.
- res_y  in  DATA_WIDTH  transformed y.
- res_valid  in  1  results valid; sampled only in WAIT_RES.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, nReset).
  - On nReset low: state=IDLE; led, op_x, op_y = 0; op_valid = 0; busy = 0.
  - Synchroniser chains cleared; debounced level db = 0; debounce counter = 0.
  - Asserting reset mid-operation abandons the transaction. No partial results are ever shown.
- Synchroniser: sw_strobe and sw_data each pass through SYNC_STAGES flops.
- Debounce: db toggles once the synchronised strobe has differed from db for DEBOUNCE_CYCLES consecutive cycles. Any glitch resets the counter to 0.
  - Edge-to-db latency is exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - Rise = db 0->1 registered this cycle; fall = db 1->0.
- FSM states and transitions (evaluated on the rise/fall of db):
  - IDLE: on rise, op_x <= synchronised sw_data -> WAIT_XLO.
  - WAIT_XLO: on fall -> WAIT_Y.
  - WAIT_Y: on rise, op_y <= synchronised sw_data -> REQ.
  - REQ: op_valid=1 until the cycle op_valid && op_ready, then -> WAIT_RES. op_x/op_y stable while op_valid=1. op_ready already high on REQ entry gives a one-cycle transfer.
  - WAIT_RES: on res_valid, register res_x/res_y internally -> SHOW_X_WAIT.
  - SHOW_X_WAIT: if db==0, led <= stored x result -> SHOW_X; else wait for fall. Covers the strobe being released before results arrive.
  - SHOW_X: on rise, led <= stored y result -> SHOW_Y.
  - SHOW_Y: on fall -> IDLE. led keeps the y result until the next SHOW_X.
- Strobe transitions arriving in REQ or WAIT_RES are not lost. SHOW_X_WAIT acts on the db level, not the edge.
- A rise in REQ/WAIT_RES followed by a fall before results arrive is treated as an early release.
- led changes only on the SHOW_X_WAIT->SHOW_X and SHOW_X->SHOW_Y transitions, and on reset.
- If sw_strobe is held high through reset release, db rises after the debounce latency and counts as an x capture (IDLE rise).
- No arithmetic in this block. Values pass through unmodified, bit-exact signed.

Decomposition:
- Shared constants package: the existing SWITCH/LED width macros. DATA_WIDTH default derives from LED width. FSM state enum typedef (ctrl_state_t) lives in the package so benches can probe the state.
- One sub-module: switch_debounce (synchroniser + counter, params SYNC_STAGES and DEBOUNCE_CYCLES; outputs db, rise, fall). Instantiated once for the strobe; sw_data uses a plain synchroniser.

Test Plan:
- Reset mid-transaction: press x=0x05, assert nReset low while in WAIT_Y -> all outputs 0, state IDLE; next full transaction works normally.
- Basic transaction: x=4, y=-8 (0xF8); stub core returns res_x=x+1, res_y=y-1 two cycles after op_ready -> op_x=0x04, op_y=0xF8 on op_valid; led=0x05 after release; led=0xF7 after second press; IDLE after final release.
- Debounce: strobe pulses of DEBOUNCE_CYCLES-1 cycles -> no state change. A pulse of exactly DEBOUNCE_CYCLES cycles -> rise after SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Backpressure: hold op_ready=0 for 20 cycles -> op_valid stays 1 with op_x/op_y stable; transfer on the first op_ready=1 cycle.
- Early release: strobe released before res_valid, with res_valid delayed 50 cycles -> led updates to res_x the cycle after capture, with no extra press needed.
- Sweep: x,y over -128..127 with the stub core -> every led sequence matches; op_valid fires exactly once per pair.
